// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per clock over a start/done handshake.
// Define DIV_SIGNED_EN to add the is_signed input for signed DIV/REM semantics.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_q;
  // The partial remainder always stays below the divisor, so only the shifted trial needs the extra bit.
  logic [WIDTH-1:0] r_p;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dzero;

  logic [WIDTH:0]   w_pShift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_dvdIn;
  logic [WIDTH-1:0] w_dvsIn;
  logic [WIDTH-1:0] w_qOut;
  logic [WIDTH-1:0] w_rOut;
  logic             w_dvsZero;

  assign w_dvsZero = (divisor == '0);
  assign w_pShift  = {r_p, r_q[WIDTH-1]};
  assign w_trial   = w_pShift - {1'b0, r_d};

`ifdef DIV_SIGNED_EN
  logic r_negQ;
  logic r_negR;
  logic w_dvdNeg;
  logic w_dvsNeg;

  assign w_dvdNeg = is_signed & dividend[WIDTH-1];
  assign w_dvsNeg = is_signed & divisor[WIDTH-1];
  // A zero divisor keeps the raw dividend in Q so it can be returned unchanged as the remainder.
  assign w_dvdIn  = (w_dvdNeg && !w_dvsZero) ? ({WIDTH{1'b0}} - dividend) : dividend;
  assign w_dvsIn  = w_dvsNeg ? ({WIDTH{1'b0}} - divisor) : divisor;
  assign w_qOut   = r_negQ ? ({WIDTH{1'b0}} - r_q) : r_q;
  assign w_rOut   = r_negR ? ({WIDTH{1'b0}} - r_p) : r_p;
`else
  assign w_dvdIn  = dividend;
  assign w_dvsIn  = divisor;
  assign w_qOut   = r_q;
  assign w_rOut   = r_p;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_d         <= '0;
      r_q         <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
      r_dzero     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_negQ      <= 1'b0;
      r_negR      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          // Returning from FINISH: busy still high here, so a start in the done cycle is dropped.
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            r_d     <= w_dvsIn;
            r_q     <= w_dvdIn;
            r_p     <= '0;
            r_cnt   <= CNT_W'(WIDTH);
            r_dzero <= w_dvsZero;
            busy    <= 1'b1;
`ifdef DIV_SIGNED_EN
            r_negQ  <= (w_dvdNeg ^ w_dvsNeg) & ~w_dvsZero;
            r_negR  <= w_dvdNeg & ~w_dvsZero;
`endif
            r_state <= w_dvsZero ? S_FINISH : S_RUN;
          end
        end
        S_RUN: begin
          if (!w_trial[WIDTH]) begin
            r_p <= w_trial[WIDTH-1:0];
            r_q <= {r_q[WIDTH-2:0], 1'b1};
          end else begin
            r_p <= w_pShift[WIDTH-1:0];
            r_q <= {r_q[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_FINISH;
        end
        S_FINISH: begin
          if (r_dzero) begin
            quotient    <= '1;
            remainder   <= r_q;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= w_qOut;
            remainder   <= w_rOut;
            div_by_zero <= 1'b0;
          end
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
